// File: rtl/trinity_tbus_pkg.sv
// Shared types for the dcache T-bus arbiter: FSM states, owner encoding,
// bus widths and the latched request payload.
package trinity_tbus_pkg;

  localparam int unsigned RESULT_W = 64;
  localparam int unsigned SRC_W    = 64;
  localparam int unsigned MASK_W   = 64;
  localparam int unsigned OPTYPE_W = 3;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tbus_state_e;

  typedef enum logic {
    OWN_LOAD = 1'b0,
    OWN_SQ   = 1'b1
  } tbus_owner_e;

  typedef struct packed {
    logic [RESULT_W-1:0] index;
    logic [SRC_W-1:0]    write_data;
    logic [MASK_W-1:0]   write_mask;
    logic [OPTYPE_W-1:0] operation_type;
  } tbus_req_t;

endpackage

// File: rtl/dcache_tbus_arbiter.sv
// Arbitrates load and store-queue requests onto the single dcache T-bus, one
// transaction at a time. Define TBUS_ARB_RR_EN for round-robin arbitration.
module dcache_tbus_arbiter
  import trinity_tbus_pkg::*;
#(
  parameter logic [STARVE_W-1:0] SQ_STARVE_MAX = 4'd8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load2arb_tbus_index_valid,
  output logic                load2arb_tbus_index_ready,
  input  logic [RESULT_W-1:0] load2arb_tbus_index,
  input  logic [OPTYPE_W-1:0] load2arb_tbus_operation_type,
  output logic                load2arb_tbus_operation_done,
  input  logic                sq2arb_tbus_index_valid,
  output logic                sq2arb_tbus_index_ready,
  input  logic [RESULT_W-1:0] sq2arb_tbus_index,
  input  logic [SRC_W-1:0]    sq2arb_tbus_write_data,
  input  logic [MASK_W-1:0]   sq2arb_tbus_write_mask,
  input  logic [OPTYPE_W-1:0] sq2arb_tbus_operation_type,
  output logic                sq2arb_tbus_operation_done,
  output logic [RESULT_W-1:0] arb2req_tbus_read_data,
  output logic                arb2dcache_tbus_index_valid,
  input  logic                arb2dcache_tbus_index_ready,
  output logic [RESULT_W-1:0] arb2dcache_tbus_index,
  output logic [SRC_W-1:0]    arb2dcache_tbus_write_data,
  output logic [MASK_W-1:0]   arb2dcache_tbus_write_mask,
  output logic [OPTYPE_W-1:0] arb2dcache_tbus_operation_type,
  input  logic [RESULT_W-1:0] arb2dcache_tbus_read_data,
  input  logic                arb2dcache_tbus_operation_done,
  input  logic                mem2dcache_flush
);

  tbus_state_e state;
  tbus_owner_e owner;
  tbus_req_t   req_q;
  tbus_req_t   load_req;
  tbus_req_t   sq_req;
  logic        valid_q;
  logic        kill;
  logic        rst_hold;
`ifdef TBUS_ARB_RR_EN
  tbus_owner_e rr_ptr;
`else
  logic [STARVE_W-1:0] starve_cnt;
`endif

  logic grant_ok;
  logic load_ok;
  logic sq_ok;
  logic sq_win;
  logic grant_any;
  logic done_fire;

  assign load_req = {load2arb_tbus_index, SRC_W'(0), MASK_W'(0), load2arb_tbus_operation_type};
  assign sq_req   = {sq2arb_tbus_index, sq2arb_tbus_write_data, sq2arb_tbus_write_mask,
                     sq2arb_tbus_operation_type};

  // Grants only from IDLE, never in the reset cycle or the cycle right after it.
  assign grant_ok = (state == ST_IDLE) && !reset_n && !rst_hold;
  assign load_ok  = grant_ok && load2arb_tbus_index_valid && !mem2dcache_flush;
  assign sq_ok    = grant_ok && sq2arb_tbus_index_valid;
`ifdef TBUS_ARB_RR_EN
  assign sq_win   = sq_ok && (!load_ok || (rr_ptr == OWN_SQ));
`else
  assign sq_win   = sq_ok && (!load_ok || (starve_cnt >= SQ_STARVE_MAX));
`endif
  assign grant_any = load_ok || sq_ok;

  assign load2arb_tbus_index_ready = load_ok && !sq_win;
  assign sq2arb_tbus_index_ready   = sq_win;

  // Completion is only honoured in WAIT; a flushed load completes silently.
  assign done_fire = (state == ST_WAIT) && arb2dcache_tbus_operation_done && !reset_n;
  assign load2arb_tbus_operation_done = done_fire && (owner == OWN_LOAD) && !kill &&
                                        !mem2dcache_flush;
  assign sq2arb_tbus_operation_done   = done_fire && (owner == OWN_SQ);
  assign arb2req_tbus_read_data       = arb2dcache_tbus_read_data;

  assign arb2dcache_tbus_index_valid    = valid_q && !reset_n;
  assign arb2dcache_tbus_index          = req_q.index;
  assign arb2dcache_tbus_write_data     = req_q.write_data;
  assign arb2dcache_tbus_write_mask     = req_q.write_mask;
  assign arb2dcache_tbus_operation_type = req_q.operation_type;

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state    <= ST_IDLE;
      owner    <= OWN_LOAD;
      req_q    <= '0;
      valid_q  <= 1'b0;
      kill     <= 1'b0;
      rst_hold <= 1'b1;
`ifdef TBUS_ARB_RR_EN
      rr_ptr   <= OWN_LOAD;
`else
      starve_cnt <= '0;
`endif
    end else begin
      rst_hold <= 1'b0;
      if ((state != ST_IDLE) && mem2dcache_flush && (owner == OWN_LOAD)) begin
        kill <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state   <= ST_REQ;
            valid_q <= 1'b1;
            owner   <= sq_win ? OWN_SQ : OWN_LOAD;
            req_q   <= sq_win ? sq_req : load_req;
          end
        end
        ST_REQ: begin
          if (arb2dcache_tbus_index_ready) begin
            state   <= ST_WAIT;
            valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (arb2dcache_tbus_operation_done) begin
            state <= ST_IDLE;
            kill  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
`ifdef TBUS_ARB_RR_EN
      if (grant_any) begin
        rr_ptr <= sq_win ? OWN_LOAD : OWN_SQ;
      end
`else
      // Counts load grants the store queue has been passed over for.
      if (!sq2arb_tbus_index_valid || sq_win) begin
        starve_cnt <= '0;
      end else if (load2arb_tbus_index_ready) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
`endif
    end
  end

endmodule
